// File: rtl/uart_pkg.sv
// Shared types and helpers for the multi-lane UART receiver.
package uart_pkg;

  // Receive lane states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_rx_state_e;

  // Widest data word any lane can be configured for
  localparam int unsigned UART_MAX_DATA_BITS = 9;

  // Expected parity bit for a (zero-extended) data word
  function automatic logic uart_parity(input logic [UART_MAX_DATA_BITS-1:0] data,
                                       input logic                          odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_lane.sv
// One UART receive lane: input synchroniser, framing FSM with 3-sample
// majority voting, shift register and a single-entry output buffer.
module uart_rx_lane
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rxd,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 err_frame,
  output logic                 err_parity,
  output logic                 err_overrun
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] SMP_LO   = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] SMP_MID  = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] SMP_HI   = CNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             PAR_ODD  = (PARITY_ODD != 0);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  // Majority of three samples taken around the bit centre
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic                 rxd_p0;
  logic                 rxd_p1;
  uart_rx_state_e       state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic                 stop_idx;
  logic                 stop_bad;
  logic                 par_err;
  logic [1:0]           smp;
  logic [DATA_BITS-1:0] shreg;
  logic                 push_p1;
  logic                 ferr_p1;
  logic                 perr_p1;
  logic [DATA_BITS-1:0] word_p1;

  logic busy;
  logic smp_lo;
  logic smp_mid;
  logic decide;
  logic bit_end;
  logic bit_maj;
  logic par_exp;
  logic pop;

  assign busy    = (state == ST_START) || (state == ST_DATA) ||
                   (state == ST_PARITY) || (state == ST_STOP);
  assign smp_lo  = tick && busy && (cnt == SMP_LO);
  assign smp_mid = tick && busy && (cnt == SMP_MID);
  assign decide  = tick && busy && (cnt == SMP_HI);
  assign bit_end = tick && busy && (cnt == BIT_END);
  assign bit_maj = maj3(smp[0], smp[1], rxd_p1);
  assign par_exp = uart_parity(UART_MAX_DATA_BITS'(shreg), PAR_ODD);
  assign pop     = rx_valid && rx_ready;

  // Two-flop synchroniser for the asynchronous serial input, idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
    end else begin
      rxd_p0 <= rxd;
      rxd_p1 <= rxd_p0;
    end
  end

  // Sample capture and data shift; pure datapath, no reset needed
  always_ff @(posedge clk) begin
    if (smp_lo)  smp[0] <= rxd_p1;
    if (smp_mid) smp[1] <= rxd_p1;
    if (decide && state == ST_DATA) shreg <= {bit_maj, shreg[DATA_BITS-1:1]};
    if (decide && state == ST_STOP) word_p1 <= shreg;
  end

  // Frame FSM: walks start/data/parity/stop bits on oversample ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      idx      <= '0;
      stop_idx <= 1'b0;
      stop_bad <= 1'b0;
      par_err  <= 1'b0;
      push_p1  <= 1'b0;
      ferr_p1  <= 1'b0;
      perr_p1  <= 1'b0;
    end else begin
      push_p1 <= 1'b0;
      ferr_p1 <= 1'b0;

      if (tick) begin
        case (state)
          ST_IDLE: begin
            if (!rxd_p1) begin
              state <= ST_START;
              cnt   <= '0;
            end
          end
          ST_WAIT_IDLE: begin
            if (rxd_p1) state <= ST_IDLE;
          end
          default: cnt <= bit_end ? '0 : cnt + CNT_W'(1);
        endcase
      end

      // Bit-centre decision once all three samples are in
      if (decide) begin
        case (state)
          ST_START: begin
            if (bit_maj) state <= ST_IDLE;
          end
          ST_PARITY: par_err <= (bit_maj != par_exp);
          ST_STOP: begin
            if (stop_idx == STOP_LAST) begin
              if (stop_bad || !bit_maj) begin
                ferr_p1 <= 1'b1;
                state   <= ST_WAIT_IDLE;
              end else begin
                push_p1 <= 1'b1;
                perr_p1 <= par_err;
                state   <= ST_IDLE;
              end
            end else begin
              stop_bad <= stop_bad | !bit_maj;
            end
          end
          default: ;
        endcase
      end

      // Bit-boundary advance
      if (bit_end) begin
        case (state)
          ST_START: begin
            state   <= ST_DATA;
            idx     <= '0;
            par_err <= 1'b0;
          end
          ST_DATA: begin
            if (idx == IDX_LAST) begin
              state    <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
              stop_idx <= 1'b0;
              stop_bad <= 1'b0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          ST_PARITY: state <= ST_STOP;
          ST_STOP:   stop_idx <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // ---- stage p1 -> output buffer ----
  // Single-entry output buffer with overrun detection and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      err_frame   <= 1'b0;
      err_parity  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_frame   <= ferr_p1;
      err_parity  <= 1'b0;
      err_overrun <= 1'b0;
      if (push_p1) begin
        err_parity <= perr_p1;
        if (!rx_valid || pop) begin
          rx_data  <= word_p1;
          rx_valid <= 1'b1;
        end else begin
          err_overrun <= 1'b1;
        end
      end else if (pop) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_rx_multi.sv
// Multi-channel UART receiver: shared oversample tick generator feeding
// CHANNELS independent receive lanes.
module uart_rx_multi
  import uart_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int BAUD_DIV_W = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [BAUD_DIV_W-1:0]               baud_div,
  input  logic [CHANNELS-1:0]                 rxd,
  output logic [CHANNELS-1:0][DATA_BITS-1:0]  rx_data,
  output logic [CHANNELS-1:0]                 rx_valid,
  input  logic [CHANNELS-1:0]                 rx_ready,
  output logic [CHANNELS-1:0]                 err_frame,
  output logic [CHANNELS-1:0]                 err_parity,
  output logic [CHANNELS-1:0]                 err_overrun
);

  logic [BAUD_DIV_W-1:0] tick_cnt;
  logic                  tick;

  assign tick = (tick_cnt == '0);

  // Shared down-counter: tick at zero, then reload with the current divider
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= baud_div;
    end else begin
      tick_cnt <= tick_cnt - BAUD_DIV_W'(1);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    uart_rx_lane #(
      .DATA_BITS  (DATA_BITS),
      .OVERSAMPLE (OVERSAMPLE),
      .PARITY_EN  (PARITY_EN),
      .PARITY_ODD (PARITY_ODD),
      .STOP_BITS  (STOP_BITS)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .rxd         (rxd[g]),
      .rx_ready    (rx_ready[g]),
      .rx_data     (rx_data[g]),
      .rx_valid    (rx_valid[g]),
      .err_frame   (err_frame[g]),
      .err_parity  (err_parity[g]),
      .err_overrun (err_overrun[g])
    );
  end

endmodule
